// File: rtl/bridge_pkg.sv
// Shared types and AXI encodings for the CPU-to-AXI4 master bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR   = 3'd1,
    ST_R    = 3'd2,
    ST_AW   = 3'd3,
    ST_W    = 3'd4,
    ST_B    = 3'd5
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;

  localparam int ID_I = 0;
  localparam int ID_D = 1;

endpackage

// File: rtl/axi_master_bridge_chk.sv
// Protocol checks for the bridge: with a single outstanding transaction every
// R/B response must carry the ID of the transaction in flight.
module axi_master_bridge_chk #(
  parameter int ID_W = 4
) (
  input logic            clock,
  input logic            reset_n,
  input logic            rvalid,
  input logic            rready,
  input logic [ID_W-1:0] rid,
  input logic            bvalid,
  input logic            bready,
  input logic [ID_W-1:0] bid,
  input logic [ID_W-1:0] exp_id
);

  a_rid_match: assert property (@(posedge clock) disable iff (!reset_n)
    (rvalid && rready) |-> (rid == exp_id));

  a_bid_match: assert property (@(posedge clock) disable iff (!reset_n)
    (bvalid && bready) |-> (bid == exp_id));

endmodule

// File: rtl/bridge_rr_arb.sv
// Two-way round-robin arbiter between the I and D request ports.
// prio_d_q set means D wins the next tie; it resets pointing at I.
module bridge_rr_arb (
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  logic prio_d_q;
  logic prio_d_d;

  // Grant selection and next-priority update.
  always_comb begin
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    prio_d_d = prio_d_q;
    if (en) begin
      if (req_i && req_d) begin
        gnt_i = ~prio_d_q;
        gnt_d = prio_d_q;
      end else begin
        gnt_i = req_i;
        gnt_d = req_d;
      end
    end else begin
      gnt_i = 1'b0;
      gnt_d = 1'b0;
    end
    if (gnt_i) begin
      prio_d_d = 1'b1;
    end else if (gnt_d) begin
      prio_d_d = 1'b0;
    end else begin
      prio_d_d = prio_d_q;
    end
  end

  // Last-grant register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prio_d_q <= 1'b0;
    end else begin
      prio_d_q <= prio_d_d;
    end
  end

endmodule

// File: rtl/axi_master_bridge.sv
// Merges the CPU instruction (read-only) and data (read/write) request ports
// onto one AXI4 master with a single transaction outstanding at a time.
module axi_master_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int USER_W = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [7:0]          i_len,
  input  logic [2:0]          i_size,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_rlast,
  output logic [1:0]          i_rresp,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [7:0]          d_len,
  input  logic [2:0]          d_size,
  output logic                d_gnt,
  input  logic                d_wvalid,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_wready,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_rlast,
  output logic [1:0]          d_rresp,
  output logic                d_bvalid,
  output logic [1:0]          d_bresp,
  output logic                awvalid,
  input  logic                awready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awprot,
  output logic [ID_W-1:0]     awid,
  output logic [USER_W-1:0]   awuser,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic                awlock,
  output logic [3:0]          awcache,
  output logic [3:0]          awqos,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [1:0]          bresp,
  input  logic [ID_W-1:0]     bid,
  output logic                arvalid,
  input  logic                arready,
  output logic [ADDR_W-1:0]   araddr,
  output logic [2:0]          arprot,
  output logic [ID_W-1:0]     arid,
  output logic [USER_W-1:0]   aruser,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic                arlock,
  output logic [3:0]          arcache,
  output logic [3:0]          arqos,
  input  logic                rvalid,
  output logic                rready,
  input  logic [1:0]          rresp,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast,
  input  logic [ID_W-1:0]     rid
);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic              is_d_q, is_d_d;

  logic              arb_en;
  logic              gnt_i_s;
  logic              gnt_d_s;
  logic              w_hs;
  logic [ID_W-1:0]   cur_id;

  // Gating with reset_n keeps the grant pulses low while reset is held.
  assign arb_en = (state_q == ST_IDLE) && reset_n;
  assign i_gnt  = gnt_i_s;
  assign d_gnt  = gnt_d_s;
  assign w_hs   = (state_q == ST_W) && d_wvalid && wready;
  assign cur_id = is_d_q ? ID_W'(ID_D) : ID_W'(ID_I);

  bridge_rr_arb u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (arb_en),
    .req_i   (i_req),
    .req_d   (d_req),
    .gnt_i   (gnt_i_s),
    .gnt_d   (gnt_d_s)
  );

  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arid    = cur_id;
  assign arprot  = 3'b000;
  assign aruser  = '0;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 1'b0;
  assign arcache = AXI_CACHE_MODIFIABLE;
  assign arqos   = 4'b0000;

  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awid    = cur_id;
  assign awprot  = 3'b000;
  assign awuser  = '0;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 1'b0;
  assign awcache = AXI_CACHE_MODIFIABLE;
  assign awqos   = 4'b0000;

  // Next-state, request latch and write beat counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    is_d_d  = is_d_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_i_s) begin
          addr_d  = i_addr;
          len_d   = i_len;
          size_d  = i_size;
          is_d_d  = 1'b0;
          state_d = ST_AR;
        end else if (gnt_d_s) begin
          addr_d  = d_addr;
          len_d   = d_len;
          size_d  = d_size;
          is_d_d  = 1'b1;
          state_d = d_we ? ST_AW : ST_AR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_AR: begin
        if (arready) begin
          state_d = ST_R;
        end else begin
          state_d = ST_AR;
        end
      end
      ST_R: begin
        if (rvalid && rlast) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_R;
        end
      end
      ST_AW: begin
        if (awready) begin
          cnt_d   = 8'd0;
          state_d = ST_W;
        end else begin
          state_d = ST_AW;
        end
      end
      ST_W: begin
        if (w_hs) begin
          if (cnt_q == len_q) begin
            state_d = ST_B;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_W;
        end
      end
      ST_B: begin
        if (bvalid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_B;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Channel handshakes and response forwarding; read data goes straight through
  // to whichever client owns the transaction, zeroed otherwise.
  always_comb begin
    arvalid  = 1'b0;
    awvalid  = 1'b0;
    rready   = 1'b0;
    wvalid   = 1'b0;
    wdata    = '0;
    wstrb    = '0;
    wlast    = 1'b0;
    d_wready = 1'b0;
    bready   = 1'b0;
    i_rvalid = 1'b0;
    i_rdata  = '0;
    i_rlast  = 1'b0;
    i_rresp  = 2'b00;
    d_rvalid = 1'b0;
    d_rdata  = '0;
    d_rlast  = 1'b0;
    d_rresp  = 2'b00;
    d_bvalid = 1'b0;
    d_bresp  = 2'b00;
    case (state_q)
      ST_AR: arvalid = 1'b1;
      ST_AW: awvalid = 1'b1;
      ST_R: begin
        rready = 1'b1;
        if (rvalid && is_d_q) begin
          d_rvalid = 1'b1;
          d_rdata  = rdata;
          d_rlast  = rlast;
          d_rresp  = rresp;
        end else if (rvalid) begin
          i_rvalid = 1'b1;
          i_rdata  = rdata;
          i_rlast  = rlast;
          i_rresp  = rresp;
        end else begin
          i_rvalid = 1'b0;
        end
      end
      ST_W: begin
        wvalid   = d_wvalid;
        wdata    = d_wdata;
        wstrb    = d_wstrb;
        wlast    = (cnt_q == len_q);
        d_wready = wready;
      end
      ST_B: begin
        bready   = 1'b1;
        d_bvalid = bvalid;
        d_bresp  = bvalid ? bresp : 2'b00;
      end
      default: begin
        arvalid = 1'b0;
      end
    endcase
  end

  // State and request registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      size_q  <= 3'd0;
      is_d_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      is_d_q  <= is_d_d;
    end
  end

  axi_master_bridge_chk #(.ID_W(ID_W)) u_chk (
    .clock   (clock),
    .reset_n (reset_n),
    .rvalid  (rvalid),
    .rready  (rready),
    .rid     (rid),
    .bvalid  (bvalid),
    .bready  (bready),
    .bid     (bid),
    .exp_id  (cur_id)
  );

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: a small AXI slave model plus request
// drivers; each scenario task checks its own expectations.
module tb_axi_master_bridge;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
  localparam int USER_W = 1;

  logic clock, reset_n;
  logic i_req, i_gnt, i_rvalid, i_rlast;
  logic [ADDR_W-1:0] i_addr;
  logic [7:0] i_len;
  logic [2:0] i_size;
  logic [DATA_W-1:0] i_rdata;
  logic [1:0] i_rresp;
  logic d_req, d_we, d_gnt, d_wvalid, d_wready, d_rvalid, d_rlast, d_bvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [7:0] d_len;
  logic [2:0] d_size;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [DATA_W/8-1:0] d_wstrb;
  logic [1:0] d_rresp, d_bresp;
  logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, arlock, rvalid, rready, rlast;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0] awprot, awsize, arprot, arsize;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [USER_W-1:0] awuser, aruser;
  logic [7:0] awlen, arlen;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, awqos, arcache, arqos;
  logic [DATA_W-1:0] wdata, rdata;
  logic [DATA_W/8-1:0] wstrb;

  axi_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .USER_W(USER_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_size(i_size), .i_gnt(i_gnt),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rresp(i_rresp),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len), .d_size(d_size), .d_gnt(d_gnt),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wready(d_wready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rresp(d_rresp),
    .d_bvalid(d_bvalid), .d_bresp(d_bresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awid(awid),
    .awuser(awuser), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awqos(awqos),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arid(arid),
    .aruser(aruser), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arqos(arqos),
    .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata), .rlast(rlast), .rid(rid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // slave configuration
  int ar_delay = 0;
  int err_beat = -1;
  logic [1:0] err_resp = 2'b00;
  bit wr_toggle = 0;
  bit tog = 1;
  // slave state
  bit rd_active = 0;
  int rd_beat = 0;
  logic [7:0] rd_len = 8'd0;
  logic [ID_W-1:0] rd_id = '0;
  logic [ADDR_W-1:0] rd_addr = '0;
  int ar_wait = 0;
  bit b_pend = 0;
  logic [ID_W-1:0] b_id_r = '0;
  // observations
  int cyc = 0;
  bit i_gnt_seen = 0, d_gnt_seen = 0;
  int ar_hs_cnt, ar_first_cyc, ar_hs_cyc;
  logic [7:0] ar_len_rec;
  logic [ID_W-1:0] ar_id_rec, aw_id_rec;
  logic [ADDR_W-1:0] ar_addr_rec;
  logic [1:0] ar_burst_rec;
  logic [3:0] ar_cache_rec;
  logic [7:0] aw_len_rec;
  int i_beats, i_last_idx, i_last_cnt, i_rlast_cyc;
  int d_beats, d_last_idx, d_last_cnt, d_rlast_cyc;
  logic [DATA_W-1:0] i_data [16];
  logic [DATA_W-1:0] d_data [16];
  logic [1:0] d_resp [16];
  int w_hs_cnt;
  logic [DATA_W-1:0] w_data [4];
  logic [7:0] w_strb [4];
  logic [3:0] w_last_v;
  int bv_cnt;
  logic [1:0] bresp_rec;
  logic [7:0] gnt_seq [$];
  int gnt_cyc [$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr();
    ar_hs_cnt = 0; ar_first_cyc = -1; ar_hs_cyc = -1; ar_wait = 0;
    i_beats = 0; i_last_idx = -1; i_last_cnt = 0; i_rlast_cyc = -1;
    d_beats = 0; d_last_idx = -1; d_last_cnt = 0; d_rlast_cyc = -1;
    w_hs_cnt = 0; w_last_v = 4'b0000; bv_cnt = 0; bresp_rec = 2'b11;
    gnt_seq.delete(); gnt_cyc.delete();
  endtask

  // AXI slave model and monitor: drive at negedge, sample settled outputs 1ns later.
  initial begin : slave
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rlast = 1'b0; rresp = 2'b00; rid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00; bid = '0;
    d_wdata = '0; d_wstrb = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (i_gnt_seen) i_req = 1'b0;
      if (d_gnt_seen) d_req = 1'b0;
      arready = arvalid && (ar_wait >= ar_delay);
      rvalid  = rd_active;
      rid     = rd_id;
      rdata   = rd_addr + 64'(rd_beat) * 64'h0000_0000_0101_0101;
      rlast   = rd_active && (rd_beat == int'(rd_len));
      rresp   = (rd_active && rd_beat == err_beat) ? err_resp : 2'b00;
      awready = awvalid;
      wready  = wr_toggle ? tog : 1'b1;
      tog     = ~tog;
      bvalid  = b_pend;
      bid     = b_id_r;
      bresp   = 2'b00;
      d_wdata = 64'hD0D0_0000_0000_0000 + 64'(w_hs_cnt);
      d_wstrb = 8'hFF ^ 8'(w_hs_cnt);
      #1;
      i_gnt_seen = i_gnt;
      d_gnt_seen = d_gnt;
      if (i_gnt) begin gnt_seq.push_back(8'h49); gnt_cyc.push_back(cyc); end
      if (d_gnt) begin gnt_seq.push_back(8'h44); gnt_cyc.push_back(cyc); end
      if (arvalid && ar_wait == 0) ar_first_cyc = cyc;
      if (arvalid && arready) begin
        ar_hs_cnt++; ar_hs_cyc = cyc; ar_wait = 0;
        ar_len_rec = arlen; ar_id_rec = arid; ar_addr_rec = araddr;
        ar_burst_rec = arburst; ar_cache_rec = arcache;
        rd_active = 1; rd_beat = 0; rd_len = arlen; rd_id = arid; rd_addr = araddr;
      end else if (arvalid) begin
        ar_wait++;
      end
      if (i_rvalid) begin
        if (i_beats < 16) i_data[i_beats] = i_rdata;
        if (i_rlast) begin i_last_idx = i_beats; i_last_cnt++; i_rlast_cyc = cyc; end
        i_beats++;
      end
      if (d_rvalid) begin
        if (d_beats < 16) begin d_data[d_beats] = d_rdata; d_resp[d_beats] = d_rresp; end
        if (d_rlast) begin d_last_idx = d_beats; d_last_cnt++; d_rlast_cyc = cyc; end
        d_beats++;
      end
      if (rvalid && rready) begin
        if (rlast) rd_active = 0;
        else rd_beat++;
      end
      if (awvalid && awready) begin aw_len_rec = awlen; aw_id_rec = awid; end
      if (wvalid && wready) begin
        if (w_hs_cnt < 4) begin
          w_data[w_hs_cnt] = wdata; w_strb[w_hs_cnt] = wstrb; w_last_v[w_hs_cnt] = wlast;
        end
        if (wlast) begin b_pend = 1; b_id_r = aw_id_rec; end
        w_hs_cnt++;
      end
      if (d_bvalid) begin bv_cnt++; bresp_rec = d_bresp; end
      if (bvalid && bready) b_pend = 0;
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    i_req = 1'b0; i_addr = '0; i_len = 8'd0; i_size = 3'd3;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_len = 8'd0; d_size = 3'd3; d_wvalid = 1'b0;
    clr();
    repeat (3) @(negedge clock);
    #2;
    i_req = 1'b1;
    #1;
    n_checks++;
    if ({arvalid, awvalid, wvalid, rready, bready, i_gnt, d_gnt, d_wready, i_rvalid, d_rvalid, d_bvalid} !== 11'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 0", {arvalid, awvalid, wvalid, rready, bready, i_gnt, d_gnt, d_wready, i_rvalid, d_rvalid, d_bvalid});
    end
    n_checks++;
    if (araddr !== 64'd0 || arlen !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h/%h want 0/0", araddr, arlen);
    end
    n_checks++;
    if ({arburst, arcache, arprot, arlock, arqos} !== {2'b01, 4'b0010, 3'b000, 1'b0, 4'b0000}) begin
      n_fail++;
      $display("FAIL const_fields: got %b", {arburst, arcache, arprot, arlock, arqos});
    end
    i_req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock); #2;
  endtask

  task automatic test_i_read();
    clr();
    ar_delay = 2;
    @(negedge clock);
    i_addr = 64'h8000_0000; i_len = 8'd3; i_size = 3'd3; i_req = 1'b1;
    for (int k = 0; k < 100 && i_last_cnt < 1; k++) begin @(negedge clock); #2; end
    repeat (2) begin @(negedge clock); #2; end
    ar_delay = 0;
    n_checks++;
    if (i_beats !== 4 || i_last_idx !== 3 || i_last_cnt !== 1) begin
      n_fail++;
      $display("FAIL i_read_beats: got beats=%0d last_idx=%0d last_cnt=%0d want 4/3/1", i_beats, i_last_idx, i_last_cnt);
    end
    n_checks++;
    if (ar_len_rec !== 8'd3 || ar_id_rec !== 4'd0 || ar_addr_rec !== 64'h8000_0000) begin
      n_fail++;
      $display("FAIL i_read_ar: got len=%0d id=%0d addr=%h want 3/0/80000000", ar_len_rec, ar_id_rec, ar_addr_rec);
    end
    n_checks++;
    if (ar_burst_rec !== 2'b01 || ar_cache_rec !== 4'b0010) begin
      n_fail++;
      $display("FAIL i_read_ar_attr: got burst=%b cache=%b want 01/0010", ar_burst_rec, ar_cache_rec);
    end
    n_checks++;
    if (gnt_seq.size() !== 1 || ar_first_cyc !== gnt_cyc[0] + 1 || ar_hs_cyc - ar_first_cyc !== 2) begin
      n_fail++;
      $display("FAIL i_read_latency: got gnts=%0d ar_first=%0d ar_hs=%0d", gnt_seq.size(), ar_first_cyc, ar_hs_cyc);
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (i_data[b] !== 64'h8000_0000 + 64'(b) * 64'h0101_0101) begin
        n_fail++;
        $display("FAIL i_read_data%0d: got %h want %h", b, i_data[b], 64'h8000_0000 + 64'(b) * 64'h0101_0101);
      end
    end
  endtask

  task automatic test_d_write();
    clr();
    wr_toggle = 1;
    @(negedge clock);
    d_we = 1'b1; d_addr = 64'h1000; d_len = 8'd1; d_size = 3'd3; d_wvalid = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 100 && bv_cnt < 1; k++) begin @(negedge clock); #2; end
    repeat (3) begin @(negedge clock); #2; end
    wr_toggle = 0; d_wvalid = 1'b0; d_we = 1'b0;
    n_checks++;
    if (w_hs_cnt !== 2 || w_last_v[1:0] !== 2'b10) begin
      n_fail++;
      $display("FAIL d_write_w: got hs=%0d wlast=%b want 2/10", w_hs_cnt, w_last_v[1:0]);
    end
    n_checks++;
    if (w_data[0] !== 64'hD0D0_0000_0000_0000 || w_data[1] !== 64'hD0D0_0000_0000_0001 || w_strb[1] !== 8'hFE) begin
      n_fail++;
      $display("FAIL d_write_data: got %h %h strb=%h", w_data[0], w_data[1], w_strb[1]);
    end
    n_checks++;
    if (bv_cnt !== 1 || bresp_rec !== 2'b00) begin
      n_fail++;
      $display("FAIL d_write_b: got bvalid_cnt=%0d bresp=%b want 1/00", bv_cnt, bresp_rec);
    end
    n_checks++;
    if (aw_len_rec !== 8'd1 || aw_id_rec !== 4'd1 || ar_hs_cnt !== 0) begin
      n_fail++;
      $display("FAIL d_write_aw: got len=%0d id=%0d ar=%0d want 1/1/0", aw_len_rec, aw_id_rec, ar_hs_cnt);
    end
  endtask

  task automatic test_d_read_err();
    logic [1:0] exp_resp [4];
    exp_resp[0] = 2'b00; exp_resp[1] = 2'b10; exp_resp[2] = 2'b00; exp_resp[3] = 2'b00;
    clr();
    err_beat = 1; err_resp = 2'b10;
    @(negedge clock);
    d_we = 1'b0; d_addr = 64'h2000; d_len = 8'd3; d_req = 1'b1;
    for (int k = 0; k < 100 && d_last_cnt < 1; k++) begin @(negedge clock); #2; end
    err_beat = -1;
    n_checks++;
    if (d_beats !== 4 || d_last_idx !== 3 || i_beats !== 0 || ar_id_rec !== 4'd1) begin
      n_fail++;
      $display("FAIL d_read_beats: got d=%0d last=%0d i=%0d id=%0d want 4/3/0/1", d_beats, d_last_idx, i_beats, ar_id_rec);
    end
    for (int b = 0; b < 4; b++) begin
      n_checks++;
      if (d_resp[b] !== exp_resp[b]) begin
        n_fail++;
        $display("FAIL d_read_resp%0d: got %b want %b", b, d_resp[b], exp_resp[b]);
      end
    end
    n_checks++;
    if (d_data[3] !== 64'h2000 + 64'h0303_0303) begin
      n_fail++;
      $display("FAIL d_read_data3: got %h want %h", d_data[3], 64'h2000 + 64'h0303_0303);
    end
  endtask

  task automatic test_arb();
    logic [7:0] exp_g;
    clr();
    for (int r = 0; r < 3; r++) begin
      @(negedge clock);
      i_addr = 64'h3000 + 64'(r) * 64'h100; i_len = 8'd0;
      d_addr = 64'h4000 + 64'(r) * 64'h100; d_len = 8'd0; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 100 && d_last_cnt < r + 1; k++) begin @(negedge clock); #2; end
      n_checks++;
      if (i_last_cnt !== r + 1 || gnt_cyc.size() !== 2 * r + 2 || gnt_cyc[2 * r + 1] !== i_rlast_cyc + 1) begin
        n_fail++;
        $display("FAIL arb_round%0d: got i_done=%0d gnts=%0d d_gnt_cyc=%0d i_rlast_cyc=%0d", r, i_last_cnt, gnt_cyc.size(), gnt_cyc[2 * r + 1], i_rlast_cyc);
      end
    end
    for (int g = 0; g < 6; g++) begin
      exp_g = (g % 2 == 0) ? 8'h49 : 8'h44;
      n_checks++;
      if (gnt_seq[g] !== exp_g) begin
        n_fail++;
        $display("FAIL arb_order%0d: got %c want %c", g, gnt_seq[g], exp_g);
      end
    end
  endtask

  task automatic test_single_then_queued();
    clr();
    @(negedge clock);
    d_we = 1'b0; d_addr = 64'h5000; d_len = 8'd0; d_req = 1'b1;
    for (int k = 0; k < 50 && gnt_seq.size() < 1; k++) begin @(negedge clock); #2; end
    @(negedge clock);
    i_addr = 64'h5800; i_len = 8'd0; i_req = 1'b1;
    for (int k = 0; k < 100 && i_last_cnt < 1; k++) begin @(negedge clock); #2; end
    n_checks++;
    if (d_beats !== 1 || d_last_idx !== 0 || d_data[0] !== 64'h5000) begin
      n_fail++;
      $display("FAIL single_beat: got beats=%0d last_idx=%0d data=%h want 1/0/5000", d_beats, d_last_idx, d_data[0]);
    end
    n_checks++;
    if (gnt_seq.size() !== 2 || gnt_seq[1] !== 8'h49 || gnt_cyc[1] !== d_rlast_cyc + 1) begin
      n_fail++;
      $display("FAIL queued_grant: got gnts=%0d i_gnt_cyc=%0d d_rlast_cyc=%0d", gnt_seq.size(), gnt_cyc[1], d_rlast_cyc);
    end
  endtask

  task automatic test_reset_mid();
    clr();
    @(negedge clock);
    i_addr = 64'h6000; i_len = 8'd7; i_req = 1'b1;
    for (int k = 0; k < 100 && i_beats < 2; k++) begin @(negedge clock); #2; end
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({arvalid, rready, i_rvalid, i_rlast, d_rvalid, wvalid, bready, d_wready, i_gnt, d_gnt} !== 10'b0 || i_rdata !== 64'd0 || araddr !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b rdata=%h araddr=%h want 0", {arvalid, rready, i_rvalid, i_rlast, d_rvalid, wvalid, bready, d_wready, i_gnt, d_gnt}, i_rdata, araddr);
    end
    rd_active = 0; b_pend = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #2;
    clr();
    @(negedge clock);
    i_addr = 64'h7000; i_len = 8'd1; i_req = 1'b1;
    for (int k = 0; k < 100 && i_last_cnt < 1; k++) begin @(negedge clock); #2; end
    n_checks++;
    if (i_beats !== 2 || i_last_idx !== 1 || i_data[1] !== 64'h7000 + 64'h0101_0101 || gnt_seq.size() !== 1) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got beats=%0d last=%0d data=%h gnts=%0d", i_beats, i_last_idx, i_data[1], gnt_seq.size());
    end
  endtask

  initial begin
    test_reset();
    test_i_read();
    test_d_write();
    test_d_read_err();
    test_arb();
    test_single_then_queued();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
